// File: rtl/weight_load_pkg.sv
// Shared definitions for the weight DRM loader.
// Holds the loader FSM state type and the fixed geometry of the weight DRM
// write port (word width, words per line, address width, checksum width).
package weight_load_pkg;

  localparam int unsigned WEIGHT_WORD_WIDTH        = 36;
  localparam int unsigned WEIGHT_WORDS_PER_LINE    = 9;
  localparam int unsigned WEIGHT_LINE_WIDTH        = WEIGHT_WORD_WIDTH * WEIGHT_WORDS_PER_LINE;
  localparam int unsigned WEIGHT_DRM_WR_ADDR_WIDTH = 10;
  localparam int unsigned WEIGHT_LEN_WIDTH         = 11;
  localparam int unsigned WEIGHT_CHECKSUM_WIDTH    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } load_state_e;

endpackage

// File: rtl/weight_line_packer.sv
// Packs consecutive input words into one DRM line.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   clear      - restart packing at lane 0 with an empty line
//   beat       - one word is accepted this cycle
//   word       - accepted word, stored at lane word_cnt (lane 0 = LSBs)
//   line_full  - pulse: this beat fills the last lane
//   line_data  - line including the word accepted this cycle
module weight_line_packer
  import weight_load_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = WEIGHT_WORD_WIDTH,
  parameter int unsigned WORDS_PER_LINE = WEIGHT_WORDS_PER_LINE,
  parameter int unsigned LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  beat,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  line_full,
  output logic [LINE_WIDTH-1:0] line_data
);

  localparam int unsigned CntWidth = $clog2(WORDS_PER_LINE);

  logic [CntWidth-1:0]   word_cnt_q, word_cnt_d;
  logic [LINE_WIDTH-1:0] pack_q, pack_d;

  always_comb begin
    pack_d     = pack_q;
    word_cnt_d = word_cnt_q;
    line_full  = beat && (word_cnt_q == CntWidth'(WORDS_PER_LINE - 1));
    if (clear) begin
      pack_d     = '0;
      word_cnt_d = '0;
    end else if (beat) begin
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
        if (word_cnt_q == CntWidth'(i)) begin
          pack_d[i*WORD_WIDTH +: WORD_WIDTH] = word;
        end
      end
      word_cnt_d = line_full ? '0 : word_cnt_q + 1'b1;
    end
  end

  // Combinational view lets the top capture the full line on the last beat.
  assign line_data = pack_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      pack_q     <= pack_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: rtl/weight_drm_loader.sv
// Write-side feeder for the weight DRM array.
// Accepts 36-bit weight words (valid/ready), packs 9 per 324-bit line and
// writes each line to the DRM at consecutive addresses from a configured base.
// Ports:
//   clk, rstn                       - DRM write clock, async active-low reset
//   cfg_start/base_addr/line_num    - load request, sampled only when idle
//   busy, done                      - load in progress / one-cycle end pulse
//   s_data, s_valid, s_ready        - input word stream
//   WeightDRM_data/valid/addr_wr    - DRM write port (valid pulses per line)
//   load_checksum                   - only with WEIGHT_LOAD_CHECKSUM_EN defined:
//                                     mod-2^32 sum of accepted words
module weight_drm_loader
  import weight_load_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = WEIGHT_WORD_WIDTH,
  parameter int unsigned WORDS_PER_LINE = WEIGHT_WORDS_PER_LINE,
  parameter int unsigned LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE,
  parameter int unsigned ADDR_WIDTH     = WEIGHT_DRM_WR_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH      = WEIGHT_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_line_num,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [LINE_WIDTH-1:0] WeightDRM_data_wr,
  output logic                  WeightDRM_valid_wr,
  output logic [ADDR_WIDTH-1:0] WeightDRM_addr_wr
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  ,
  output logic [WEIGHT_CHECKSUM_WIDTH-1:0] load_checksum
`endif
);

  load_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic                  zero_done_q;
  logic                  wr_valid_q;
  logic [LINE_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic                  beat;
  logic                  accept_start;
  logic                  zero_start;
  logic                  line_full;
  logic                  last_line;
  logic [LINE_WIDTH-1:0] line_data;

  assign s_ready      = (state_q == StLoad);
  assign busy         = (state_q == StLoad);
  assign done         = (state_q == StDone) || zero_done_q;
  assign beat         = s_valid && s_ready;
  assign accept_start = (state_q == StIdle) && cfg_start && (cfg_line_num != '0);
  assign zero_start   = (state_q == StIdle) && cfg_start && (cfg_line_num == '0);
  assign last_line    = line_full && (line_cnt_q == len_q - LEN_WIDTH'(1));

  assign WeightDRM_valid_wr = wr_valid_q;
  assign WeightDRM_data_wr  = wr_data_q;
  assign WeightDRM_addr_wr  = wr_addr_q;

  weight_line_packer #(
    .WORD_WIDTH     (WORD_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINE_WIDTH     (LINE_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (accept_start),
    .beat      (beat),
    .word      (s_data),
    .line_full (line_full),
    .line_data (line_data)
  );

  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept_start) begin
          state_d    = StLoad;
          line_cnt_d = '0;
        end
      end
      StLoad: begin
        if (line_full) begin
          line_cnt_d = line_cnt_q + LEN_WIDTH'(1);
          if (last_line) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      line_cnt_q  <= '0;
      zero_done_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      zero_done_q <= zero_start;
      wr_valid_q  <= line_full;
      if (accept_start) begin
        base_q <= cfg_base_addr;
        len_q  <= cfg_line_num;
      end
      // Data and address hold between strobes; the add wraps at 2^ADDR_WIDTH.
      if (line_full) begin
        wr_data_q <= line_data;
        wr_addr_q <= base_q + line_cnt_q[ADDR_WIDTH-1:0];
      end
    end
  end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [WEIGHT_CHECKSUM_WIDTH-1:0] checksum_q;

  // Bits above 31 of each word cannot affect a mod-2^32 sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      checksum_q <= '0;
    end else if (accept_start) begin
      checksum_q <= '0;
    end else if (beat) begin
      checksum_q <= checksum_q + s_data[WEIGHT_CHECKSUM_WIDTH-1:0];
    end
  end

  assign load_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_drm_loader.sv
module tb_weight_drm_loader;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cfg_start;
  logic [9:0]   cfg_base_addr;
  logic [10:0]  cfg_line_num;
  logic         busy;
  logic         done;
  logic [35:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [323:0] WeightDRM_data_wr;
  logic         WeightDRM_valid_wr;
  logic [9:0]   WeightDRM_addr_wr;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [31:0]  load_checksum;
`endif

  weight_drm_loader dut (
    .clk                (clk),
    .rstn               (rstn),
    .cfg_start          (cfg_start),
    .cfg_base_addr      (cfg_base_addr),
    .cfg_line_num       (cfg_line_num),
    .busy               (busy),
    .done               (done),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .WeightDRM_data_wr  (WeightDRM_data_wr),
    .WeightDRM_valid_wr (WeightDRM_valid_wr),
    .WeightDRM_addr_wr  (WeightDRM_addr_wr)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    .load_checksum      (load_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int ready_cnt = 0;

  logic [35:0]  words[$];
  logic [323:0] got_data[$];
  logic [9:0]   got_addr[$];
  int           got_cyc[$];
  int           done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (WeightDRM_valid_wr) begin
      got_data.push_back(WeightDRM_data_wr);
      got_addr.push_back(WeightDRM_addr_wr);
      got_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (s_ready) ready_cnt <= ready_cnt + 1;
  end

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_vec(input string tag, input logic [323:0] obs, input logic [323:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
    check_int({tag, "_ready"}, int'(s_ready), 0);
    check_int({tag, "_valid_wr"}, int'(WeightDRM_valid_wr), 0);
    check_vec({tag, "_data_wr"}, WeightDRM_data_wr, '0);
    check_int({tag, "_addr_wr"}, int'(WeightDRM_addr_wr), 0);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    check_int({tag, "_checksum"}, int'(load_checksum), 0);
`endif
  endtask

  // mode: 0 random words, 1 words 1..N, 2 all ones, 3 reuse previous words.
  // Called and returns at a falling edge with the DUT idle.
  task automatic do_load(input logic [9:0] base, input int num, input int gap_pct,
                         input int mode, input bit mid_start);
    int           nbeats;
    int           idx;
    int           guard;
    int           exp_cyc[$];
    logic [63:0]  rnd;
    logic [323:0] line;
    longint       total;
    nbeats = 9 * num;
    if (mode != 3) begin
      words.delete();
      for (int i = 0; i < nbeats; i++) begin
        rnd = {$urandom, $urandom};
        if (mode == 1) words.push_back(36'(i + 1));
        else if (mode == 2) words.push_back(36'hF_FFFF_FFFF);
        else words.push_back(rnd[35:0]);
      end
    end
    got_data.delete(); got_addr.delete(); got_cyc.delete(); done_cyc.delete();
    cfg_start = 1'b1; cfg_base_addr = base; cfg_line_num = 11'(num);
    @(negedge clk);
    cfg_start = 1'b0; cfg_base_addr = 10'($urandom); cfg_line_num = 11'($urandom);
    check_int("busy_in_load", int'(busy), 1);
    idx = 0; guard = 0;
    while (idx < nbeats && guard < 2000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      rnd = {$urandom, $urandom};
      s_data = s_valid ? words[idx] : rnd[35:0];
      cfg_start = mid_start && (idx == 12);
      if (s_valid && s_ready) begin
        if (idx % 9 == 8) exp_cyc.push_back(cyc + 1);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    cfg_start = 1'b0;
    check_int("beats_accepted", idx, nbeats);
    check_int("ready_after_last", int'(s_ready), 0);
    check_int("done_after_last", int'(done), 1);
    check_int("busy_after_last", int'(busy), 0);
    total = 0;
    for (int i = 0; i < nbeats; i++) total += longint'(words[i]);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    check_int("checksum_at_done", int'(load_checksum), int'(32'(total)));
`endif
    // Extra word offered after the load must never be taken.
    s_valid = 1'b1; s_data = '1;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    check_int("ready_after_done", int'(s_ready), 0);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    check_int("checksum_stable", int'(load_checksum), int'(32'(total)));
`endif
    check_int("strobe_count", got_data.size(), num);
    for (int k = 0; k < num && k < got_data.size(); k++) begin
      line = '0;
      for (int i = 0; i < 9; i++) line |= 324'(words[9*k + i]) << (36 * i);
      check_vec("line_data", got_data[k], line);
      check_int("line_addr", int'(got_addr[k]), (int'(base) + k) % 1024);
      if (k < exp_cyc.size()) check_int("strobe_cycle", got_cyc[k], exp_cyc[k]);
    end
    check_int("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && exp_cyc.size() == num)
      check_int("done_cycle", done_cyc[0], exp_cyc[num-1]);
  endtask

  initial begin
    int t;
    int rc;
    logic [63:0] rnd;
    rstn = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_line_num = '0;
    s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    do_load(10'd0, 1, 0, 1, 1'b0);
    do_load(10'd1022, 3, 0, 0, 1'b0);
    do_load(10'd77, 2, 0, 0, 1'b0);
    do_load(10'd77, 2, 50, 3, 1'b0);

    // Zero-length request: done pulse only.
    got_data.delete(); done_cyc.delete();
    rc = ready_cnt;
    cfg_start = 1'b1; cfg_base_addr = 10'd5; cfg_line_num = '0; t = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    check_int("zero_done", int'(done), 1);
    check_int("zero_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    check_int("zero_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check_int("zero_done_cycle", done_cyc[0], t + 1);
    check_int("zero_strobes", got_data.size(), 0);
    check_int("zero_ready", ready_cnt - rc, 0);

    do_load(10'd300, 2, 0, 0, 1'b1);

    // Reset after 5 beats of line 0.
    got_data.delete();
    cfg_start = 1'b1; cfg_base_addr = 10'd500; cfg_line_num = 11'd1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd = {$urandom, $urandom};
      s_valid = 1'b1; s_data = rnd[35:0];
      @(negedge clk);
    end
    s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_int("abort_no_strobe", got_data.size(), 0);
    do_load(10'd600, 1, 0, 0, 1'b0);

    for (int n = 0; n < 4; n++)
      do_load(10'($urandom), $urandom_range(1, 4), $urandom_range(0, 60), 0, 1'b0);

    do_load(10'd10, 1, 0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
